float_vector_packer: RTL
========================

Name: float_vector_packer

Overview:
- Upstream producer for the 16-lane float argmin tree.
- Accepts a scalar AXI-stream of SIZE-bit floats and packs 16 consecutive beats into one 16-lane vector beat.
- Beat k of a group goes to lane k.
- Short groups, terminated early by tlast, are padded with PAD_VALUE. The default pad is +infinity, so padded lanes never win an argmin.
- Output is one registered vector beat plus one fill buffer, so input streams without bubbles while the output drains.

Parameters:
- SIZE, 64, float width in bits (16/32/64).
- PAD_VALUE, {1'b0, all-ones exponent, zero mantissa} for SIZE (64: 64'h7FF0_0000_0000_0000), fill value for unsupplied lanes.

Ports:
- aclk  in  1  clock, all logic rising-edge.
- areset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  SIZE  scalar float.
- s_axis_tvalid  in  1  scalar beat valid.
- s_axis_tready  out  1  packer can accept a beat.
- s_axis_tlast  in  1  closes the current group early (or on lane 15).
- m_axis_tdata  out  [15:0][SIZE-1:0]  packed vector; lane i = element i.
- m_axis_tvalid  out  1  vector valid.
- m_axis_tready  in  1  downstream accepts vector.

Behaviour:
- Interface decision: one clock (aclk); reset areset is asynchronous and active-high.
- State:
  - lane counter cnt[3:0]
  - fill buffer fbuf[15:0] plus flag fbuf_full
  - output register obuf plus m_axis_tvalid
- Reset values: cnt=0, fbuf_full=0, m_axis_tvalid=0, m_axis_tdata=all lanes PAD_VALUE, s_axis_tready=0 while areset is high.
- s_axis_tready = !fbuf_full (registered-free, combinational from state).
- Accept means s_axis_tvalid && s_axis_tready. On accept:
  - fbuf[cnt] <= tdata.
  - Group closes when cnt==15 or tlast=1.
  - On close, lanes cnt+1..15 take PAD_VALUE and cnt <= 0.
  - Otherwise cnt <= cnt+1.
- Transfer on close: if obuf is free this cycle (!m_axis_tvalid, or m_axis_tready), the completed vector loads obuf directly and m_axis_tvalid=1 next cycle. Latency from closing beat to m_axis_tvalid is 1 cycle.
- If obuf is stalled on close: fbuf_full <= 1 and input stalls.
- When obuf later drains (m_axis_tvalid && m_axis_tready) with fbuf_full=1: fbuf moves to obuf, fbuf_full <= 0, and m_axis_tvalid stays 1.
- Throughput: with m_axis_tready held high, one vector per 16 input beats and s_axis_tready never drops.
- tlast on lane 15 is a normal close. A group of more than 16 beats without tlast is split every 16 beats with no error.
- tlast on the first beat (cnt==0) yields lane 0 = data, lanes 1..15 = PAD_VALUE.
- Same-cycle close and drain: obuf loads the new vector and m_axis_tvalid stays 1, with no bubble.
- m_axis_tdata/tvalid stay stable while tvalid && !tready (AXI rule).
- Reset mid-group or mid-stall: the partial group and any pending vectors are discarded; all state returns to reset values.

Optional Feature:
- Macro: FLOAT_VECTOR_PACKER_LANE_MASK_EN.
- Defined: adds output port m_axis_tuser[15:0].
  - Bit i = 1 iff lane i holds real data (not padding).
  - It travels with the vector through fbuf/obuf, with the same stability rules.
  - Reset value is 16'h0000.
- Undefined: port absent; padding is the only short-group indication.

Decomposition:
- Shared package float_pkg holds:
  - localparam NUM_LANES=16 and LANE_W=4
  - function float_pos_inf(SIZE), returning the default PAD_VALUE
  - typedef of the lane-vector type used here and by float_multi_argmin
- Natural sub-module: float_vector_slice, the single-entry vector register slice (obuf plus valid, with the stall/transfer logic). Keep the fill side inline.

Test Plan:
- Stream values 1.0..16.0 (double), tlast on beat 16, m_axis_tready=1 → one vector with lane i=(i+1).0; tvalid exactly 1 cycle after the 16th accept; s_axis_tready constant 1.
- 5 beats (7.0,3.0,9.0,2.0,4.0) with tlast on beat 5 → lanes 0-4 = data, lanes 5-15 = 64'h7FF0_0000_0000_0000; with LANE_MASK_EN, tuser = 16'h001F.
- Two back-to-back 16-beat groups with m_axis_tready=0 → first vector held stable; s_axis_tready drops after the 32nd accept. Assert tready → vector 1, then vector 2 on the next cycle; s_axis_tready returns to 1.
- 40 beats without tlast → vectors of beats 0-15 and 16-31; beats 32-39 remain pending with no output until a tlast beat closes them as an 8-lane vector plus padding.
- Assert areset after 9 beats with a stalled vector in obuf → m_axis_tvalid=0 and s_axis_tready=0 during reset. A fresh 16-beat group afterwards emits only the new data, with no stale lanes.
- Random tvalid/tready throttling over 1000 groups with random lengths 1-16 → scoreboard matches every lane and the padding; no beat is lost or duplicated.

Source files
------------

// File: rtl/float_pkg.sv
// Shared float-lane definitions for the 16-lane packer and argmin tree.
package float_pkg;

   localparam int NUM_LANES = 16;
   localparam int LANE_W    = 4;

   typedef logic [NUM_LANES-1:0]       lane_mask_t;
   typedef logic [NUM_LANES-1:0][63:0] f64_vec_t;

   // +infinity bit pattern, right-aligned in 64 bits, for 16/32/64-bit floats.
   function automatic logic [63:0] float_pos_inf(input int size);
      case (size)
         16:      float_pos_inf = 64'h0000_0000_0000_7C00;
         32:      float_pos_inf = 64'h0000_0000_7F80_0000;
         default: float_pos_inf = 64'h7FF0_0000_0000_0000;
      endcase
   endfunction

endpackage

// File: rtl/float_vector_slice.sv
// Single-entry vector register slice: holds one vector until downstream takes it.
// Lane mask sideband is carried when FLOAT_VECTOR_PACKER_LANE_MASK_EN is defined.
module float_vector_slice
   import float_pkg::*;
#(
   parameter int              SIZE      = 64,
   parameter logic [SIZE-1:0] PAD_VALUE = SIZE'(float_pos_inf(SIZE))
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [NUM_LANES-1:0][SIZE-1:0] in_data,
`ifdef FLOAT_VECTOR_PACKER_LANE_MASK_EN
   input  lane_mask_t                     in_user,
   output lane_mask_t                     out_user,
`endif
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [NUM_LANES-1:0][SIZE-1:0] out_data
);

   // A transfer happens on a side when valid && ready; the held vector never
   // changes while out_valid && !out_ready.
   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= {NUM_LANES{PAD_VALUE}};
      end else if (in_ready) begin
         out_valid <= in_valid;
         if (in_valid) out_data <= in_data;
      end
   end

`ifdef FLOAT_VECTOR_PACKER_LANE_MASK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                       out_user <= '0;
      else if (in_ready && in_valid) out_user <= in_user;
   end
`endif

endmodule

// File: rtl/float_vector_packer.sv
// Packs 16 scalar float beats into one 16-lane vector, padding short groups.
// Optional lane-valid mask on m_axis_tuser with FLOAT_VECTOR_PACKER_LANE_MASK_EN.
module float_vector_packer
   import float_pkg::*;
#(
   parameter int              SIZE      = 64,
   parameter logic [SIZE-1:0] PAD_VALUE = SIZE'(float_pos_inf(SIZE))
) (
   input  logic                           aclk,
   input  logic                           areset,
   input  logic [SIZE-1:0]                s_axis_tdata,
   input  logic                           s_axis_tvalid,
   output logic                           s_axis_tready,
   input  logic                           s_axis_tlast,
   output logic [NUM_LANES-1:0][SIZE-1:0] m_axis_tdata,
   output logic                           m_axis_tvalid,
`ifdef FLOAT_VECTOR_PACKER_LANE_MASK_EN
   output lane_mask_t                     m_axis_tuser,
`endif
   input  logic                           m_axis_tready
);

   logic [LANE_W-1:0]              cnt;
   logic [NUM_LANES-1:0][SIZE-1:0] fbuf;
   logic [NUM_LANES-1:0][SIZE-1:0] close_vec;
   logic [NUM_LANES-1:0][SIZE-1:0] load_vec;
   logic                           fbuf_full;
   logic                           accept;
   logic                           close;
   logic                           load_valid;
   logic                           load_ready;

   assign s_axis_tready = !fbuf_full && !areset;
   assign accept        = s_axis_tvalid && s_axis_tready;
   assign close         = accept && (s_axis_tlast || (cnt == LANE_W'(NUM_LANES-1)));

   // Completed vector as it looks including the closing beat and padding.
   always_comb begin
      close_vec = fbuf;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (LANE_W'(i) == cnt)     close_vec[i] = s_axis_tdata;
         else if (LANE_W'(i) > cnt) close_vec[i] = PAD_VALUE;
      end
   end

   assign load_valid = fbuf_full || close;
   assign load_vec   = fbuf_full ? fbuf : close_vec;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         cnt       <= '0;
         fbuf_full <= 1'b0;
         fbuf      <= {NUM_LANES{PAD_VALUE}};
      end else if (accept) begin
         if (close) begin
            cnt <= '0;
            if (!load_ready) begin
               fbuf      <= close_vec;
               fbuf_full <= 1'b1;
            end
         end else begin
            cnt       <= cnt + LANE_W'(1);
            fbuf[cnt] <= s_axis_tdata;
         end
      end else if (fbuf_full && load_ready) begin
         fbuf_full <= 1'b0;
      end
   end

`ifdef FLOAT_VECTOR_PACKER_LANE_MASK_EN
   lane_mask_t fbuf_user;
   lane_mask_t close_user;
   lane_mask_t load_user;

   always_comb begin
      close_user = '0;
      for (int i = 0; i < NUM_LANES; i++) close_user[i] = (LANE_W'(i) <= cnt);
   end

   assign load_user = fbuf_full ? fbuf_user : close_user;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset)                     fbuf_user <= '0;
      else if (close && !load_ready)  fbuf_user <= close_user;
   end
`endif

   float_vector_slice #(
      .SIZE      (SIZE),
      .PAD_VALUE (PAD_VALUE)
   ) u_obuf (
      .clk       (aclk),
      .rst       (areset),
      .in_valid  (load_valid),
      .in_ready  (load_ready),
      .in_data   (load_vec),
`ifdef FLOAT_VECTOR_PACKER_LANE_MASK_EN
      .in_user   (load_user),
      .out_user  (m_axis_tuser),
`endif
      .out_valid (m_axis_tvalid),
      .out_ready (m_axis_tready),
      .out_data  (m_axis_tdata)
   );

endmodule
